bus_arbiter: RTL and testbench

Round-robin arbiter for the shared 32-bit CPU datapath bus. Register outputs, PC, MDR, ALU result and immediate sources each raise a request to drive the bus. The arbiter grants exactly one driver at a time, holds the grant while the request stays high, and inserts a one-cycle turnaround between owners so no two drivers ever overlap. Its one-hot grant vector feeds the bus encoder/multiplexer in place of hand-asserted `*out` strobes.

---
 rtl/bus_arb_pkg.sv | 27 ++
 rtl/bus_arbiter_if.sv | 35 +++
 rtl/rr_priority_picker.sv | 59 +++++
 rtl/bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the CPU datapath bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_e;

    // Default configuration
    localparam int DEF_NUM_REQ  = 8;
    localparam int DEF_MAX_HOLD = 4;

    // Bus driver slots on the shared datapath bus
    localparam int REQ_REG_A = 0;
    localparam int REQ_REG_B = 1;
    localparam int REQ_PC    = 2;
    localparam int REQ_MDR   = 3;
    localparam int REQ_ALU   = 4;
    localparam int REQ_IMM   = 5;
    localparam int REQ_SP    = 6;
    localparam int REQ_TMP   = 7;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus drivers and the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requests are levels, grants are one-hot or zero.
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               bus_busy;
    logic               preempt;

    // Drivers raise requests and observe the grant
    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  bus_busy,
        input  preempt
    );

    // Arbiter samples requests and produces the grant
    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output bus_busy,
        output preempt
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Round-robin pick: rotate req by ptr, take lowest set bit, rotate index back.
// Latency: combinational.
// Backpressure: none.
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    localparam logic [IDX_W:0] NUM_L = NUM_REQ[IDX_W:0];

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_rot_idx;
    logic [IDX_W:0]     w_sum;

    assign any = |req;

    // Rotate so that requester ptr lands at bit 0
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rot[i] = req[IDX_W'((i + int'(ptr)) % NUM_REQ)];
        end
    end

    // Lowest set bit of the rotated vector is the highest-priority requester
    always_comb begin
        w_rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx = IDX_W'(i);
            end
        end
    end

    // Undo the rotation: add ptr back modulo NUM_REQ
    always_comb begin
        w_sum = {1'b0, w_rot_idx} + {1'b0, ptr};
        if (w_sum >= NUM_L) begin
            w_sum = w_sum - NUM_L;
        end
        idx = w_sum[IDX_W-1:0];
    end

    // One-hot form of the winning index, empty when nobody asks
    always_comb begin
        winner = '0;
        if (any) begin
            winner[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter, one-cycle turnaround between owners; BUS_ARB_TIMEOUT_EN adds hold-timeout preemption.
// Latency: 1 cycle request-to-grant from IDLE, release visible 1 cycle after req drops; all outputs registered.
// Backpressure: owner keeps the bus while its req is high (until MAX_HOLD cycles if contended and timeout enabled).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic          clk,
    input  logic          clr,
    bus_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // Reject configurations the arbiter cannot represent
    if (NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_num_req
        $error("bus_arbiter: NUM_REQ must be in 2..32");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("bus_arbiter: MAX_HOLD must be at least 1");
    end

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_win;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;
    logic               w_owner_req;
    logic               w_timeout;
    logic               w_load;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_pre_nxt;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_win),
        .idx    (w_win_idx),
        .any    (w_any)
    );

    // r_grant_idx names the owner whenever the FSM sits in GRANT
    assign w_owner_req = bus.req[r_grant_idx];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_hold;
    logic             r_preempt;
    logic             w_others;

    assign w_others  = |(bus.req & ~r_grant);
    assign w_timeout = (r_hold == HOLD_SAT) && w_others;

    // Hold counter: cleared on each new grant, counts owner cycles, saturates
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_hold <= '0;
        end else if (w_load) begin
            r_hold <= '0;
        end else if (r_state == GRANT && r_hold != HOLD_SAT) begin
            r_hold <= r_hold + CNT_W'(1);
        end
    end

    // Preempt flag is a registered pulse coinciding with the TURN cycle
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_pre_nxt;
        end
    end

    assign bus.preempt = r_preempt;
`else
    assign w_timeout   = 1'b0;
    assign bus.preempt = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: GRANT always passes through TURN before a new owner
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_any ? GRANT : IDLE;
            GRANT:   w_state_nxt = (!w_owner_req || w_timeout) ? TURN : GRANT;
            TURN:    w_state_nxt = w_any ? GRANT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next values for the grant, index, pointer and preempt registers
    always_comb begin
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_grant_idx;
        w_ptr_nxt   = r_ptr;
        w_pre_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE, TURN: begin
                w_grant_nxt = '0;
                if (w_any) begin
                    w_grant_nxt = w_win;
                    w_idx_nxt   = w_win_idx;
                    w_load      = 1'b1;
                    w_ptr_nxt   = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                    : w_win_idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_grant_nxt = '0;
                end else if (w_timeout) begin
                    w_grant_nxt = '0;
                    w_pre_nxt   = 1'b1;
                end
            end
            default: w_grant_nxt = '0;
        endcase
    end

    // Output and pointer registers; reset drops any grant at once
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_idx_nxt;
            r_busy      <= |w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_grant_idx;
    assign bus.bus_busy  = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a cycle-level reference model feeding a scoreboard.
// Latency: expected outputs are queued when inputs are driven and compared after the next edge.
// Backpressure: n/a.
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_REQ(N)) bus_if ();

    bus_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [N-1:0] grant;
        logic [1:0]   idx;
        logic         busy;
        logic         pre;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 idle, 1 owning, 2 turnaround
    int           m_state = 0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    logic [N-1:0] m_grant = '0;
    logic [1:0]   m_idx   = '0;
    logic         m_pre   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge with the given sampled inputs
    task automatic model_edge(input logic [N-1:0] r, input logic c);
        bit to_en;
        bit found;
        int k;
`ifdef BUS_ARB_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        if (!c) begin
            m_state = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_grant = '0; m_idx = '0; m_pre = 1'b0;
            return;
        end
        m_pre = 1'b0;
        if (m_state != 1) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                k = (m_ptr + j) % N;
                if (!found && r[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_grant = '0;
                    m_grant[k] = 1'b1;
                    m_idx   = 2'(k);
                    m_ptr   = (k + 1) % N;
                    m_cnt   = 0;
                    m_state = 1;
                end
            end
            if (!found) begin
                m_grant = '0;
                m_state = 0;
            end
        end else begin
            if (!r[m_owner]) begin
                m_grant = '0;
                m_state = 2;
            end else if (to_en && m_cnt == MH - 1 && (r & ~m_grant) != '0) begin
                m_grant = '0;
                m_pre   = 1'b1;
                m_state = 2;
            end else if (m_cnt < MH - 1) begin
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the model's prediction, compare after the edge
    task automatic step(input logic [N-1:0] r, input logic c);
        exp_t e;
        @(negedge clk);
        bus_if.req = r;
        clr        = c;
        model_edge(r, c);
        sb_q.push_back('{grant: m_grant, idx: m_idx, busy: |m_grant, pre: m_pre});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("grant",     32'(bus_if.grant),     32'(e.grant));
        chk("grant_idx", 32'(bus_if.grant_idx), 32'(e.idx));
        chk("bus_busy",  32'(bus_if.bus_busy),  32'(e.busy));
        chk("preempt",   32'(bus_if.preempt),   32'(e.pre));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int zeros;
        int budget;
        int run;
        int pre_seen;
        int g_cnt;
        bit ended;
        int rr_order[4];
        rr_order = '{0, 1, 3, 0};
        bus_if.req = '0;

        // Reset held with all requests raised: bus stays idle
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0);
            chk("reset_grant", 32'(bus_if.grant), 32'h0);
        end
        step(4'b1111, 1'b1);
        chk("first_grant", 32'(bus_if.grant), 32'h1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Single requester from IDLE, then release
        step(4'b0100, 1'b1);
        chk("single_grant", 32'(bus_if.grant), 32'h4);
        chk("single_idx", 32'(bus_if.grant_idx), 32'd2);
        step(4'b0000, 1'b1);
        chk("single_release", 32'(bus_if.grant), 32'h0);
        step(4'b0000, 1'b1);

        // Round-robin: pointer back to 0, owners release after 2 cycles
        step(4'b0000, 1'b0);
        zeros = 0;
        for (int n = 0; n < 4; n++) begin
            budget = 8;
            while (bus_if.grant == '0 && budget > 0) begin
                step(4'b1011, 1'b1);
                if (bus_if.grant == '0) zeros++;
                budget--;
            end
            chk("rr_grant_seen", 32'(bus_if.grant != '0), 32'd1);
            chk("rr_order", 32'(bus_if.grant_idx), 32'(rr_order[n]));
            if (n > 0) chk("rr_gap", 32'(zeros), 32'd1);
            step(4'b1011, 1'b1);
            step(4'b1011 & ~(4'b0001 << bus_if.grant_idx), 1'b1);
            zeros = (bus_if.grant == '0) ? 1 : 0;
        end

        // Contended hold: two requesters held constant
        step(4'b0000, 1'b0);
        run = 0; pre_seen = 0; ended = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0011, 1'b1);
            if (!ended && bus_if.grant == 4'b0001) run++;
            else if (run > 0) ended = 1'b1;
            if (bus_if.preempt) pre_seen++;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        chk("timeout_run", 32'(run), 32'(MH));
        chk("timeout_preempts", 32'(pre_seen), 32'd4);
`else
        chk("no_timeout_run", 32'(run), 32'd20);
        chk("no_timeout_preempts", 32'(pre_seen), 32'd0);
`endif

        // Uncontended hold keeps the bus indefinitely
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        g_cnt = 0; pre_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0010, 1'b1);
            if (bus_if.grant == 4'b0010) g_cnt++;
            if (bus_if.preempt) pre_seen++;
        end
        chk("uncontended_cycles", 32'(g_cnt), 32'd20);
        chk("uncontended_preempt", 32'(pre_seen), 32'd0);

        // Reset in the middle of a grant, then pointer restarts at 0
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b1);
        chk("mid_grant", 32'(bus_if.grant), 32'h8);
        step(4'b1000, 1'b0);
        chk("mid_reset_drop", 32'(bus_if.grant), 32'h0);
        step(4'b1001, 1'b1);
        chk("post_reset_winner", 32'(bus_if.grant), 32'h1);

        // Request dropped as its grant appears still gets one cycle
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b1);
        chk("short_grant", 32'(bus_if.grant), 32'h4);
        step(4'b0000, 1'b1);
        chk("short_release", 32'(bus_if.grant), 32'h0);
        chk("short_idx_hold", 32'(bus_if.grant_idx), 32'd2);
        step(4'b0000, 1'b1);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
